// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and defaults for the pipeline hold controller
// Purpose: FSM state encodings, parameter defaults and counter widths shared by
//          pipe_hold_ctrl and hold_timeout_cnt.
// Ports:   none (package).
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int FLUSH_CYC_DEF = 2;
  localparam int TO_CYC_DEF    = 1023;
  localparam int CNT_W         = 4;
  localparam int TO_W          = 10;

endpackage

// File: rtl/pipe_hold_ctrl_if.sv
// rtl/pipe_hold_ctrl_if.sv - pipeline hold/flush control bundle
// Purpose: groups the hazard/stall requests from the pipeline and the
//          stage-register enables, flush strobes and redirect back to it.
// Ports:   master = pipeline side (drives requests, receives controls)
//          slave  = pipe_hold_ctrl (receives requests, drives controls)
interface pipe_hold_ctrl_if;
  logic        bus_wait_i;
  logic        jump_req_i;
  logic [31:0] jump_addr_i;
  logic        ex_busy_i;
  logic        id_hazard_i;
  logic        pc_en_o;
  logic        ifid_en_o;
  logic        idex_en_o;
  logic        exmem_en_o;
  logic        ifid_flush_o;
  logic        idex_flush_o;
  logic        exmem_flush_o;
  logic        jump_o;
  logic [31:0] jump_addr_o;
  logic        busy_o;
  logic        err_o;

  modport master (
    output bus_wait_i, jump_req_i, jump_addr_i, ex_busy_i, id_hazard_i,
    input  pc_en_o, ifid_en_o, idex_en_o, exmem_en_o,
    input  ifid_flush_o, idex_flush_o, exmem_flush_o,
    input  jump_o, jump_addr_o, busy_o, err_o
  );

  modport slave (
    input  bus_wait_i, jump_req_i, jump_addr_i, ex_busy_i, id_hazard_i,
    output pc_en_o, ifid_en_o, idex_en_o, exmem_en_o,
    output ifid_flush_o, idex_flush_o, exmem_flush_o,
    output jump_o, jump_addr_o, busy_o, err_o
  );
endinterface

// File: rtl/hold_timeout_cnt.sv
// rtl/hold_timeout_cnt.sv - stall watchdog for the pipeline hold controller
// Purpose: counts consecutive stalled cycles; after TO_CYC of them raises a
//          one-cycle registered err pulse and starts counting again.
// Ports:   clk, rst (sync, active-low), stall (ex_busy | bus_wait), err (pulse)
module hold_timeout_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  output logic err
);

  // Compare against TO_CYC-1 so the pulse follows exactly the TO_CYC-th stalled cycle.
  localparam logic [TO_W-1:0] LAST = 10'(TO_CYC - 1);

  logic [TO_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      if (!stall) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        cnt_q <= '0;
        err   <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 10'd1;
      end
    end
  end

endmodule

// File: rtl/zero_rst_dff.sv
// rtl/zero_rst_dff.sv - plain register cleared to zero by synchronous active-low reset
// Purpose: shared state flop; loads d every cycle, clears to zero while rst=0.
// Ports:   clk, rst (sync, active-low), d (next value), q (registered value)
module zero_rst_dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) q <= '0;
    else      q <= d;
  end

endmodule

// File: rtl/pipe_hold_ctrl.sv
// rtl/pipe_hold_ctrl.sv - stall/flush/redirect controller for a 4-stage pipeline
// Purpose: combinationally derives stage enables, flush strobes and PC redirect
//          from the IDLE/FLUSH/WAIT FSM and the hazard requests.
//          Optional stall watchdog enabled by macro PIPE_HOLD_TIMEOUT_EN.
// Ports:   clk, rst (sync, active-low), pif (pipe_hold_ctrl_if.slave)
// Params:  FLUSH_CYC (flush cycles per taken jump, 1..15), TO_CYC (timeout, 10-bit)
module pipe_hold_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYC = FLUSH_CYC_DEF,
  parameter int TO_CYC    = TO_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hold_ctrl_if.slave   pif
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = 4'(FLUSH_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             state_legal;

  zero_rst_dff #(.W(2))     u_state (.clk(clk), .rst(rst), .d(state_d), .q(state_q));
  zero_rst_dff #(.W(CNT_W)) u_cnt   (.clk(clk), .rst(rst), .d(cnt_d),   .q(cnt_q));

  assign state_legal = (state_q == ST_IDLE) || (state_q == ST_FLUSH) || (state_q == ST_WAIT);

  always_comb begin
    pif.pc_en_o       = 1'b1;
    pif.ifid_en_o     = 1'b1;
    pif.idex_en_o     = 1'b1;
    pif.exmem_en_o    = 1'b1;
    pif.ifid_flush_o  = 1'b0;
    pif.idex_flush_o  = 1'b0;
    pif.exmem_flush_o = 1'b0;
    pif.jump_o        = 1'b0;
    pif.jump_addr_o   = 32'h0;
    state_d           = state_q;
    cnt_d             = cnt_q;

    if (!rst) begin
      // Hold every stage register at its default value while in reset.
      pif.pc_en_o       = 1'b0;
      pif.ifid_en_o     = 1'b0;
      pif.idex_en_o     = 1'b0;
      pif.exmem_en_o    = 1'b0;
      pif.ifid_flush_o  = 1'b1;
      pif.idex_flush_o  = 1'b1;
      pif.exmem_flush_o = 1'b1;
      state_d           = ST_IDLE;
      cnt_d             = '0;
    end else if (pif.bus_wait_i) begin
      // Whole pipe frozen; FSM holds unless it is somehow in an illegal state.
      pif.pc_en_o    = 1'b0;
      pif.ifid_en_o  = 1'b0;
      pif.idex_en_o  = 1'b0;
      pif.exmem_en_o = 1'b0;
      if (!state_legal) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end else if (pif.jump_req_i && state_legal) begin
      pif.jump_o       = 1'b1;
      pif.jump_addr_o  = pif.jump_addr_i;
      pif.ifid_flush_o = 1'b1;
      pif.idex_flush_o = 1'b1;
      if (FLUSH_CYC > 1) begin
        state_d = ST_FLUSH;
        cnt_d   = CNT_RELOAD;
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        ST_FLUSH: begin
          pif.ifid_flush_o = 1'b1;
          pif.idex_flush_o = 1'b1;
          if (cnt_q <= 4'd1) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_IDLE, ST_WAIT: begin
          if (pif.ex_busy_i) begin
            // Hold IF/ID/EX and feed a bubble into MEM while EX is occupied.
            pif.pc_en_o       = 1'b0;
            pif.ifid_en_o     = 1'b0;
            pif.idex_en_o     = 1'b0;
            pif.exmem_flush_o = 1'b1;
            state_d           = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
            if (pif.id_hazard_i) begin
              pif.pc_en_o      = 1'b0;
              pif.ifid_en_o    = 1'b0;
              pif.idex_flush_o = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign pif.busy_o = rst && (state_q != ST_IDLE);

`ifdef PIPE_HOLD_TIMEOUT_EN
  logic stall;
  logic err_q;

  assign stall = pif.ex_busy_i | pif.bus_wait_i;

  hold_timeout_cnt #(.TO_CYC(TO_CYC)) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .err   (err_q)
  );

  // Registered pulse is masked during reset so err_o is 0 from the first reset cycle.
  assign pif.err_o = rst & err_q;
`else
  logic [TO_W-1:0] unused_to_cyc;
  assign unused_to_cyc = 10'(TO_CYC);
  assign pif.err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// tb/tb_pipe_hold_ctrl.sv - self-checking bench for pipe_hold_ctrl
module tb_pipe_hold_ctrl;

  typedef struct {
    string       name;
    logic        rst;
    logic        bus_wait;
    logic        jump;
    logic        ex_busy;
    logic        hazard;
    logic [31:0] addr;
    logic [6:0]  ctl;   // {pc_en, ifid_en, idex_en, exmem_en, ifid_fl, idex_fl, exmem_fl}
    logic        exp_jump;
    logic [31:0] exp_addr;
    logic        exp_busy;
    logic        exp_err;
  } vec_t;

  localparam logic [6:0] C_DEF = 7'b1111_000;
  localparam logic [6:0] C_RST = 7'b0000_111;
  localparam logic [6:0] C_BW  = 7'b0000_000;
  localparam logic [6:0] C_FL  = 7'b1111_110;
  localparam logic [6:0] C_STL = 7'b0001_001;
  localparam logic [6:0] C_HAZ = 7'b0011_010;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  pipe_hold_ctrl_if pif ();

  pipe_hold_ctrl #(.FLUSH_CYC(2), .TO_CYC(8)) dut (
    .clk (clk),
    .rst (rst),
    .pif (pif)
  );

  function automatic vec_t mk(input string nm, input logic r, input logic bw, input logic jr,
                              input logic eb, input logic hz, input logic [31:0] a,
                              input logic [6:0] c, input logic ej, input logic [31:0] ea,
                              input logic eby, input logic ee);
    vec_t v;
    v.name = nm; v.rst = r; v.bus_wait = bw; v.jump = jr; v.ex_busy = eb; v.hazard = hz;
    v.addr = a; v.ctl = c; v.exp_jump = ej; v.exp_addr = ea; v.exp_busy = eby; v.exp_err = ee;
    return v;
  endfunction

  task automatic check_out();
    vec_t        e;
    logic [6:0]  act_ctl;
    e = exp_q.pop_front();
    act_ctl = {pif.pc_en_o, pif.ifid_en_o, pif.idex_en_o, pif.exmem_en_o,
               pif.ifid_flush_o, pif.idex_flush_o, pif.exmem_flush_o};
    n_cmp++;
    if (act_ctl !== e.ctl || pif.jump_o !== e.exp_jump || pif.jump_addr_o !== e.exp_addr ||
        pif.busy_o !== e.exp_busy || pif.err_o !== e.exp_err) begin
      n_bad++;
      $display("FAIL %s: got ctl=%b jump=%b addr=%h busy=%b err=%b, want ctl=%b jump=%b addr=%h busy=%b err=%b",
               e.name, act_ctl, pif.jump_o, pif.jump_addr_o, pif.busy_o, pif.err_o,
               e.ctl, e.exp_jump, e.exp_addr, e.exp_busy, e.exp_err);
    end
  endtask

  // Drive one cycle of stimulus just after posedge, record the expectation,
  // then compare at the following negedge once the combinational outputs settle.
  task automatic step(input vec_t v);
    rst             = v.rst;
    pif.bus_wait_i  = v.bus_wait;
    pif.jump_req_i  = v.jump;
    pif.ex_busy_i   = v.ex_busy;
    pif.id_hazard_i = v.hazard;
    pif.jump_addr_i = v.addr;
    exp_q.push_back(v);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic te;
    rst = 1'b0;
    pif.bus_wait_i = 1'b0; pif.jump_req_i = 1'b0; pif.ex_busy_i = 1'b0;
    pif.id_hazard_i = 1'b0; pif.jump_addr_i = 32'h0;

    //            name          rst bw jr eb hz addr          ctl    jmp addr         busy err
    tbl.push_back(mk("rst0",     0, 0, 0, 0, 0, 32'h0,        C_RST, 0, 32'h0,        0, 0));
    tbl.push_back(mk("rst1",     0, 1, 1, 1, 1, 32'h1234,     C_RST, 0, 32'h0,        0, 0));
    tbl.push_back(mk("idle0",    1, 0, 0, 0, 0, 32'h0,        C_DEF, 0, 32'h0,        0, 0));
    tbl.push_back(mk("hazard",   1, 0, 0, 0, 1, 32'h0,        C_HAZ, 0, 32'h0,        0, 0));
    tbl.push_back(mk("idle1",    1, 0, 0, 0, 0, 32'h0,        C_DEF, 0, 32'h0,        0, 0));
    tbl.push_back(mk("jump100",  1, 0, 1, 0, 0, 32'h100,      C_FL,  1, 32'h100,      0, 0));
    tbl.push_back(mk("flush100", 1, 0, 0, 0, 0, 32'h0,        C_FL,  0, 32'h0,        1, 0));
    tbl.push_back(mk("idle2",    1, 0, 0, 0, 0, 32'h0,        C_DEF, 0, 32'h0,        0, 0));
    tbl.push_back(mk("bw_jump",  1, 1, 1, 0, 0, 32'hDEADBEEF, C_BW,  0, 32'h0,        0, 0));
    tbl.push_back(mk("idle3",    1, 0, 0, 0, 0, 32'h0,        C_DEF, 0, 32'h0,        0, 0));
    tbl.push_back(mk("exb_haz",  1, 0, 0, 1, 1, 32'h0,        C_STL, 0, 32'h0,        0, 0));
    tbl.push_back(mk("wait_out", 1, 0, 0, 0, 0, 32'h0,        C_DEF, 0, 32'h0,        1, 0));
    tbl.push_back(mk("idle4",    1, 0, 0, 0, 0, 32'h0,        C_DEF, 0, 32'h0,        0, 0));
    tbl.push_back(mk("jump200",  1, 0, 1, 0, 0, 32'h200,      C_FL,  1, 32'h200,      0, 0));
    tbl.push_back(mk("bw_flush", 1, 1, 0, 0, 0, 32'h0,        C_BW,  0, 32'h0,        1, 0));
    tbl.push_back(mk("flush200", 1, 0, 0, 0, 0, 32'h0,        C_FL,  0, 32'h0,        1, 0));
    tbl.push_back(mk("idle5",    1, 0, 0, 0, 0, 32'h0,        C_DEF, 0, 32'h0,        0, 0));
    tbl.push_back(mk("jmp_exb",  1, 0, 1, 1, 1, 32'h300,      C_FL,  1, 32'h300,      0, 0));
    tbl.push_back(mk("fl_exb",   1, 0, 0, 1, 0, 32'h0,        C_FL,  0, 32'h0,        1, 0));
    tbl.push_back(mk("exb",      1, 0, 0, 1, 0, 32'h0,        C_STL, 0, 32'h0,        0, 0));
    tbl.push_back(mk("wait_jmp", 1, 0, 1, 0, 0, 32'h400,      C_FL,  1, 32'h400,      1, 0));
    tbl.push_back(mk("flush400", 1, 0, 0, 0, 0, 32'h0,        C_FL,  0, 32'h0,        1, 0));
    tbl.push_back(mk("idle6",    1, 0, 0, 0, 0, 32'h0,        C_DEF, 0, 32'h0,        0, 0));

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Five-cycle EX stall, then defaults (busy lingers one cycle while leaving WAIT).
    for (int i = 0; i < 5; i++)
      step(mk("stall5", 1, 0, 0, 1, 0, 32'h0, C_STL, 0, 32'h0, (i != 0), 0));
    step(mk("stall5_end", 1, 0, 0, 0, 0, 32'h0, C_DEF, 0, 32'h0, 1, 0));
    step(mk("stall5_idle", 1, 0, 0, 0, 0, 32'h0, C_DEF, 0, 32'h0, 0, 0));

    // Jump re-requested in the FLUSH cycle extends the flush by two more cycles.
    step(mk("rej_a", 1, 0, 1, 0, 0, 32'h500, C_FL,  1, 32'h500, 0, 0));
    step(mk("rej_b", 1, 0, 1, 0, 0, 32'h600, C_FL,  1, 32'h600, 1, 0));
    step(mk("rej_c", 1, 0, 0, 0, 0, 32'h0,   C_FL,  0, 32'h0,   1, 0));
    step(mk("rej_d", 1, 0, 0, 0, 0, 32'h0,   C_DEF, 0, 32'h0,   0, 0));

    // Reset while in WAIT aborts the stall.
    step(mk("rw_a", 1, 0, 0, 1, 0, 32'h0, C_STL, 0, 32'h0, 0, 0));
    step(mk("rw_b", 1, 0, 0, 1, 0, 32'h0, C_STL, 0, 32'h0, 1, 0));
    step(mk("rw_rst", 0, 0, 0, 1, 0, 32'h0, C_RST, 0, 32'h0, 0, 0));
    step(mk("rw_idle", 1, 0, 0, 0, 0, 32'h0, C_DEF, 0, 32'h0, 0, 0));

    // Ten stalled cycles against TO_CYC=8: one pulse in the cycle after the 8th.
    for (int i = 0; i < 10; i++) begin
`ifdef PIPE_HOLD_TIMEOUT_EN
      te = (i == 8);
`else
      te = 1'b0;
`endif
      step(mk("timeout", 1, 0, 0, 1, 0, 32'h0, C_STL, 0, 32'h0, (i != 0), te));
    end
    step(mk("to_end", 1, 0, 0, 0, 0, 32'h0, C_DEF, 0, 32'h0, 1, 0));
    step(mk("to_idle", 1, 0, 0, 0, 0, 32'h0, C_DEF, 0, 32'h0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hold_ctrl.md
PIPE_HOLD_CTRL -- requirements
Module: pipe_hold_ctrl

Interface
REQ-001 The block SHALL have parameter FLUSH_CYC, default 2, giving the total flush cycles per taken jump (range 1..15).
REQ-002 The block SHALL have parameter TO_CYC, default 1023, giving the stall-timeout limit in cycles (10-bit).
REQ-003 The block SHALL have port clk, input, 1, clock; all state updates on posedge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous, active-low.
REQ-005 The block SHALL have port bus_wait_i, input, 1, MEM-stage bus not ready (freeze whole pipe).
REQ-006 The block SHALL have port jump_req_i, input, 1, EX resolved a taken branch/jump.
REQ-007 The block SHALL have port jump_addr_i, input, 32, jump target.
REQ-008 The block SHALL have port ex_busy_i, input, 1, multi-cycle EX op (mul/div) in progress.
REQ-009 The block SHALL have port id_hazard_i, input, 1, load-use hazard in ID.
REQ-010 The block SHALL have port pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, output, 1 each, stage-register update enables.
REQ-011 The block SHALL have port ifid_flush_o, idex_flush_o, exmem_flush_o, output, 1 each, load-default-value strobes for the pipeline registers.
REQ-012 The block SHALL have port jump_o, output, 1, PC redirect; jump_addr_o, output, 32, redirect target.
REQ-013 The block SHALL have port busy_o, output, 1, FSM not IDLE; err_o, output, 1, stall-timeout pulse.

Function
REQ-014 Outputs SHALL be combinational from FSM state and inputs, so stall and flush take effect in the request cycle with zero latency.
REQ-015 Defaults with no request SHALL be: all *_en_o=1, all *_flush_o=0, jump_o=0, jump_addr_o=0.
REQ-016 Priority SHALL be bus_wait_i > jump_req_i/FLUSH state > ex_busy_i > id_hazard_i.
REQ-017 bus_wait_i=1 SHALL force all *_en_o=0 and all *_flush_o=0; jump_o SHALL be held off; FSM state and counters SHALL freeze.
REQ-018 jump_req_i=1 (no bus_wait) SHALL give jump_o=1, jump_addr_o=jump_addr_i, ifid_flush_o=1, idex_flush_o=1 in that cycle. If FLUSH_CYC>1, the FSM SHALL enter FLUSH with cnt=FLUSH_CYC-1.
REQ-019 In FLUSH, ifid_flush_o=idex_flush_o=1 each cycle. cnt SHALL decrement, and the FSM SHALL return to IDLE on the cycle cnt reaches 1.
REQ-020 A jump_req_i during FLUSH SHALL be accepted: redirect again and reload cnt=FLUSH_CYC-1.
REQ-021 ex_busy_i=1 (IDLE, no jump) SHALL give pc_en_o=ifid_en_o=idex_en_o=0 and exmem_flush_o=1, and the FSM SHALL enter WAIT. The FSM SHALL return to IDLE the first cycle ex_busy_i=0.
REQ-022 id_hazard_i=1 alone SHALL give pc_en_o=ifid_en_o=0 and idex_flush_o=1 for each cycle asserted.
REQ-023 ex_busy_i and id_hazard_i together SHALL resolve to the ex_busy_i response only.
REQ-024 Legal states SHALL be IDLE, FLUSH, WAIT; an illegal encoding SHALL return to IDLE next cycle.

Reset
REQ-025 While rst=0 the block SHALL drive all *_en_o=0, all *_flush_o=1, jump_o=0, jump_addr_o=0, busy_o=0, err_o=0.
REQ-026 Reset SHALL set state=IDLE, cnt=0, timeout counter=0 on the next posedge, aborting any FLUSH/WAIT mid-operation.
REQ-027 The first cycle after rst=1 SHALL show the REQ-015 defaults.

Configuration
REQ-028 Macro PIPE_HOLD_TIMEOUT_EN defined: a 10-bit counter SHALL count consecutive cycles with ex_busy_i|bus_wait_i high and SHALL clear when both are low. On reaching TO_CYC, err_o SHALL pulse 1 cycle (registered), the counter SHALL clear, and stall behaviour SHALL still follow the inputs.
REQ-029 Macro absent: err_o SHALL be tied 0 and no counter logic SHALL be present.

Structure
REQ-030 The state encodings (IDLE=2'd0, FLUSH=2'd1, WAIT=2'd2) and the FLUSH_CYC/TO_CYC defaults SHALL live in shared package pipe_ctrl_pkg.
REQ-031 The timeout logic SHALL be sub-module hold_timeout_cnt, instantiated only under PIPE_HOLD_TIMEOUT_EN. State/cnt registers SHALL use the codebase's zero-reset flop.

Verification
REQ-032 Jump, FLUSH_CYC=2: jump_req_i=1, addr=0x0000_0100 for 1 cycle -> jump_o=1, addr out 0x100, ifid/idex flush high for 2 cycles, busy_o=1 for 1 cycle.
REQ-033 Stall: ex_busy_i high 5 cycles -> pc/ifid/idex_en=0 and exmem_flush_o=1 for exactly 5 cycles, then defaults.
REQ-034 Load-use: id_hazard_i 1 cycle -> pc_en_o=ifid_en_o=0, idex_flush_o=1 that cycle only.
REQ-035 Collisions: bus_wait_i with jump_req_i -> no redirect, all en=0; jump_req_i repeated in 2nd FLUSH cycle -> redirect, flush extends 2 more cycles.
REQ-036 Reset mid-WAIT: rst=0 during ex_busy_i -> reset outputs per REQ-025; after release, IDLE defaults.
REQ-037 Timeout (macro on, TO_CYC=8): ex_busy_i held 10 cycles -> single err_o pulse after 8th cycle; macro off -> err_o stays 0.
